// File: rtl/logic_lab_unit_if.sv
// Switch, button and LED signals of logic_lab_unit; master drives the board inputs, slave is the unit.
interface logic_lab_unit_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw_a;
    logic [WIDTH-1:0] sw_b;
    logic [2:0]       sw_op;
    logic             btn_go;
    logic [WIDTH-1:0] led_result;
    logic             led_zero;
    logic             led_busy;
    logic             done;
    logic [7:0]       exec_count;

    modport master (
        output sw_a, sw_b, sw_op, btn_go,
        input  led_result, led_zero, led_busy, done, exec_count
    );

    modport slave (
        input  sw_a, sw_b, sw_op, btn_go,
        output led_result, led_zero, led_busy, done, exec_count
    );
endinterface

// File: rtl/logic_lab_unit.sv
// logic_lab_unit: debounced button evaluates an 8-function bitwise op; result DEBOUNCE_CYCLES+3 clocks after press, once per press.
// No backpressure; define LOGIC_LAB_UNIT_BLINK_EN to blink led_result while the button is held/released (HOLD).
module logic_lab_unit #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_CYCLES    = 8
) (
    input  logic            clk,
    input  logic            rst,
    logic_lab_unit_if.slave io
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS, EXEC, HOLD} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, btn_s_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic [7:0]       count_q, count_d;

    function automatic logic [WIDTH-1:0] alu(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0]       op);
        case (op)
            3'd0:    return a;
            3'd1:    return a | b;
            3'd2:    return a & b;
            3'd3:    return a ^ b;
            3'd4:    return ~a;
            3'd5:    return ~(a | b);
            3'd6:    return ~(a & b);
            default: return ~(a ^ b);
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EXEC: begin
                // Switches are read raw here: they are static while the button is in use.
                result_d = alu(io.sw_a, io.sw_b, io.sw_op);
                zero_d   = (alu(io.sw_a, io.sw_b, io.sw_op) == '0);
                done_d   = 1'b1;
                count_d  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                state_d  = HOLD;
                cnt_d    = '0;
            end
            HOLD: begin
                if (btn_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef LOGIC_LAB_UNIT_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic          phase_q, phase_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    // Phase restarts solid on every HOLD entry and is forced solid outside HOLD.
    always_comb begin
        phase_d = 1'b1;
        bcnt_d  = '0;
        if (state_q == HOLD && state_d == HOLD) begin
            if (bcnt_q == BLINK_LAST) begin
                phase_d = ~phase_q;
                bcnt_d  = '0;
            end else begin
                phase_d = phase_q;
                bcnt_d  = bcnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b1;
            bcnt_q  <= '0;
        end else begin
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign io.led_result = result_q & {WIDTH{phase_q}};
`else
    assign io.led_result = result_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b0;
            btn_s_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= io.btn_go;
            btn_s_q  <= sync1_q;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign io.led_zero   = zero_q;
    assign io.led_busy   = (state_q != IDLE);
    assign io.done       = done_q;
    assign io.exec_count = count_q;
endmodule
